// File: rtl/heartbeat_seq_if.sv
// Handshake/bus bundle for heartbeat_seq: run controls, frame-memory write port and display outputs.
// The duty input exists only when HEARTBEAT_SEQ_PWM_EN is defined.
interface heartbeat_seq_if #(
  parameter int NUM_DIGITS = 4,
  parameter int FRAME_AW   = 3,
  parameter int CNT_W      = 25
);
  logic                    enable;
  logic [1:0]              mode;
  logic [FRAME_AW:0]       num_frames;
  logic [CNT_W-1:0]        step_cycles;
  logic [CNT_W-1:0]        gap_cycles;
  logic                    wr_en;
  logic [FRAME_AW-1:0]     wr_addr;
  logic [NUM_DIGITS*8-1:0] wr_data;
`ifdef HEARTBEAT_SEQ_PWM_EN
  logic [3:0]              duty;
`endif
  logic [NUM_DIGITS*8-1:0] dig;
  logic [FRAME_AW-1:0]     frame_idx;
  logic                    busy;
  logic                    cycle_done;

  modport master (
`ifdef HEARTBEAT_SEQ_PWM_EN
    output duty,
`endif
    output enable, mode, num_frames, step_cycles, gap_cycles,
    output wr_en, wr_addr, wr_data,
    input  dig, frame_idx, busy, cycle_done
  );

  modport slave (
`ifdef HEARTBEAT_SEQ_PWM_EN
    input  duty,
`endif
    input  enable, mode, num_frames, step_cycles, gap_cycles,
    input  wr_en, wr_addr, wr_data,
    output dig, frame_idx, busy, cycle_done
  );
endinterface

// File: rtl/heartbeat_seq.sv
// Multi-digit 7-segment animation sequencer with loop/bounce/one-shot playback and gap timing.
// Optional PWM dimming of the segment outputs is enabled by defining HEARTBEAT_SEQ_PWM_EN.
module heartbeat_seq #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_FRAMES = 8,
  parameter int FRAME_AW   = 3,
  parameter int CNT_W      = 25
) (
  input logic            clk,
  input logic            reset,
  heartbeat_seq_if.slave bus
);
  localparam int DW = NUM_DIGITS * 8;
  localparam logic [DW-1:0]     BLANK  = '1;
  localparam logic [FRAME_AW:0] MAX_NF = (FRAME_AW + 1)'(MAX_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_HALT} state_t;

  logic [DW-1:0] mem [MAX_FRAMES];

  state_t              state_q, state_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [FRAME_AW-1:0] frame_idx_q, frame_idx_d;
  logic                dir_down_q, dir_down_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic                busy_q, busy_d;
  logic                cycle_done_q, cycle_done_d;
  logic [FRAME_AW:0]   nf_clamped;
  logic                is_last;

  // Frame memory has no reset so it survives a reset pulse.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !reset) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    nf_clamped = (bus.num_frames > MAX_NF) ? MAX_NF : bus.num_frames;
    // Written without subtraction so num_frames==0 makes every frame the last one.
    is_last    = ({1'b0, frame_idx_q} + (FRAME_AW + 1)'(1)) >= nf_clamped;
  end

  always_comb begin
    state_d      = state_q;
    dig_d        = BLANK;
    frame_idx_d  = frame_idx_q;
    dir_down_d   = dir_down_q;
    timer_d      = timer_q;
    cycle_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.num_frames != '0) begin
          state_d     = S_PLAY;
          frame_idx_d = '0;
          dir_down_d  = 1'b0;
          timer_d     = '0;
        end
      end
      S_PLAY: begin
        dig_d = mem[frame_idx_q];
        if (timer_q >= bus.step_cycles) begin
          timer_d = '0;
          case (bus.mode)
            2'b01: begin
              if (!dir_down_q) begin
                if (!is_last) begin
                  frame_idx_d = frame_idx_q + 1'b1;
                end else if (frame_idx_q == '0) begin
                  state_d = S_GAP;
                end else begin
                  dir_down_d  = 1'b1;
                  frame_idx_d = frame_idx_q - 1'b1;
                end
              end else if (frame_idx_q != '0) begin
                frame_idx_d = frame_idx_q - 1'b1;
              end else begin
                state_d    = S_GAP;
                dir_down_d = 1'b0;
              end
            end
            2'b10: begin
              if (!is_last) begin
                frame_idx_d = frame_idx_q + 1'b1;
              end else begin
                state_d      = S_HALT;
                cycle_done_d = 1'b1;
              end
            end
            default: begin
              if (!is_last) begin
                frame_idx_d = frame_idx_q + 1'b1;
              end else begin
                state_d = S_GAP;
              end
            end
          endcase
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q >= bus.gap_cycles) begin
          cycle_done_d = 1'b1;
          state_d      = S_PLAY;
          frame_idx_d  = '0;
          dir_down_d   = 1'b0;
          timer_d      = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        dig_d = dig_q;
      end
    endcase

    if (!bus.enable) begin
      state_d      = S_IDLE;
      dig_d        = BLANK;
      frame_idx_d  = '0;
      dir_down_d   = 1'b0;
      timer_d      = '0;
      cycle_done_d = 1'b0;
    end

    busy_d = (state_d == S_PLAY) || (state_d == S_GAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dig_q        <= BLANK;
      frame_idx_q  <= '0;
      dir_down_q   <= 1'b0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dig_q        <= dig_d;
      frame_idx_q  <= frame_idx_d;
      dir_down_q   <= dir_down_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      cycle_done_q <= cycle_done_d;
    end
  end

`ifdef HEARTBEAT_SEQ_PWM_EN
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0] dig_pwm_q, dig_pwm_d;

  // dig_q keeps the unforced pattern so HALT holds the frame, not a dimmed blank.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    dig_pwm_d = (pwm_cnt_q > bus.duty) ? BLANK : dig_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      dig_pwm_q <= BLANK;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      dig_pwm_q <= dig_pwm_d;
    end
  end

  assign bus.dig = dig_pwm_q;
`else
  assign bus.dig = dig_q;
`endif

  assign bus.frame_idx  = frame_idx_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_heartbeat_seq.sv
// Self-checking bench for heartbeat_seq: directed steps plus randomized playback runs
// compared against a per-cycle schedule built from the playback rules.
module tb_heartbeat_seq;
  localparam int ND   = 4;
  localparam int MAXF = 8;
  localparam int AW   = 3;
  localparam int CW   = 25;
  localparam int DW   = ND * 8;
  localparam int GAPB = 100;
  localparam int HLTB = 200;
  localparam logic [DW-1:0] ONES = '1;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;

  logic [DW-1:0] mem_m [MAXF];
  int            sched[$];
  int            sched_len;
  bit            sched_once;
  int            sched_nf;

  heartbeat_seq_if #(.NUM_DIGITS(ND), .FRAME_AW(AW), .CNT_W(CW)) bus ();

  heartbeat_seq #(.NUM_DIGITS(ND), .MAX_FRAMES(MAXF), .FRAME_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_frame(input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
    mem_m[addr] = data;
  endtask

  // Entry codes: <GAPB frame shown in PLAY; GAPB+f gap; HLTB+f halted.
  function automatic int sched_at(input int k);
    if (sched_once && k >= sched_len) return HLTB + sched_nf - 1;
    return sched[k % sched_len];
  endfunction

  task automatic run_check(input int md, input int nfin, input int st, input int gp);
    int nf, ncyc, ent, prv;
    logic [DW-1:0] dexp;
    bit bounce, exp_done;
    nf         = (nfin > MAXF) ? MAXF : nfin;
    bounce     = (md == 1);
    sched_once = (md == 2);
    sched_nf   = nf;
    sched.delete();
    for (int f = 0; f < nf; f++) repeat (st + 1) sched.push_back(f);
    if (bounce) for (int f = nf - 2; f >= 0; f--) repeat (st + 1) sched.push_back(f);
    if (!sched_once) repeat (gp + 1) sched.push_back(GAPB + (bounce ? 0 : nf - 1));
    sched_len = sched.size();
    ncyc = sched_once ? sched_len + 5 : 2 * sched_len + 3;
    if (ncyc > 300) ncyc = 300;

    bus.mode        = 2'(md);
    bus.num_frames  = (AW + 1)'(nfin);
    bus.step_cycles = CW'(st);
    bus.gap_cycles  = CW'(gp);
    bus.enable      = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      ent = sched_at(k);
      prv = (k == 0) ? -1 : sched_at(k - 1);
      if (ent >= HLTB)              dexp = mem_m[nf - 1];
      else if (prv >= 0 && prv < GAPB) dexp = mem_m[prv];
      else                           dexp = ONES;
      exp_done = sched_once ? (k == sched_len) : (k > 0 && (k % sched_len) == 0);
      chk("dig", 64'(bus.dig), 64'(dexp));
      chk("frame_idx", 64'(bus.frame_idx), 64'(ent % GAPB));
      chk("busy", 64'(bus.busy), 64'(ent < HLTB));
      chk("cycle_done", 64'(bus.cycle_done), 64'(exp_done));
    end
    bus.enable = 1'b0;
    tick();
    chk("abort_dig", 64'(bus.dig), 64'(ONES));
    chk("abort_idx", 64'(bus.frame_idx), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.cycle_done), 64'd0);
    $display("run mode=%0d nf=%0d step=%0d gap=%0d cycles=%0d vectors=%0d miscompares=%0d",
             md, nfin, st, gp, ncyc, vectors, errors);
  endtask

  initial begin
    int cnt;
    vectors = 0;
    errors  = 0;
    reset   = 1'b1;
    bus.enable = 1'b0; bus.mode = 2'b00; bus.num_frames = '0;
    bus.step_cycles = '0; bus.gap_cycles = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef HEARTBEAT_SEQ_PWM_EN
    bus.duty = 4'd15;
`endif
    #2;
    chk("reset_dig", 64'(bus.dig), 64'(ONES));
    chk("reset_idx", 64'(bus.frame_idx), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.cycle_done), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    for (int a = 0; a < MAXF; a++) write_frame(a, DW'($urandom));
    write_frame(0, 32'h1111_1111);
    write_frame(1, 32'h2222_2222);
    write_frame(2, 32'h3333_3333);

    run_check(0, 3, 1, 2);   // loop
    run_check(1, 3, 1, 2);   // bounce
    run_check(1, 1, 1, 2);   // bounce, single frame
    run_check(2, 3, 1, 2);   // one-shot, halt on 0x33333333
    run_check(3, 3, 0, 0);   // mode 11 behaves as loop

    // Asynchronous reset mid-clock while playing; memory must survive.
    bus.mode = 2'b00; bus.num_frames = 4'd3; bus.step_cycles = CW'(1); bus.enable = 1'b1;
    repeat (4) tick();
    #3 reset = 1'b1;
    #1;
    chk("async_dig", 64'(bus.dig), 64'(ONES));
    chk("async_idx", 64'(bus.frame_idx), 64'd0);
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_done", 64'(bus.cycle_done), 64'd0);
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    run_check(0, 3, 1, 2);

    // num_frames=0 never leaves IDLE.
    bus.num_frames = '0; bus.enable = 1'b1;
    repeat (4) tick();
    chk("nf0_busy", 64'(bus.busy), 64'd0);
    chk("nf0_dig", 64'(bus.dig), 64'(ONES));
    bus.enable = 1'b0;
    tick();

    // Overwrite the displayed frame: visible two cycles after the strobe.
    bus.mode = 2'b00; bus.num_frames = 4'd1; bus.step_cycles = CW'(30); bus.enable = 1'b1;
    repeat (4) tick();
    chk("wr_before", 64'(bus.dig), 64'(mem_m[0]));
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 32'h4444_4444;
    tick();
    bus.wr_en = 1'b0;
    chk("wr_plus1", 64'(bus.dig), 64'(mem_m[0]));
    mem_m[0] = 32'h4444_4444;
    tick();
    chk("wr_plus2", 64'(bus.dig), 64'h4444_4444);
    bus.enable = 1'b0;
    tick();

`ifdef HEARTBEAT_SEQ_PWM_EN
    bus.duty = 4'd3; bus.enable = 1'b1;
    repeat (3) tick();
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus.dig === mem_m[0]) cnt++;
    end
    chk("pwm_duty3_on", 64'(cnt), 64'd4);
    bus.enable = 1'b0; bus.duty = 4'd15;
    tick();
`else
    cnt = 0;
`endif

    for (int r = 0; r < 24; r++) begin
      if (r % 4 == 0) write_frame(int'($urandom_range(0, MAXF - 1)), DW'($urandom));
      run_check(int'($urandom_range(0, 3)), int'($urandom_range(1, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
